// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and encodings for the instruction fetch controller.
// Imported by inst_fetch_ctrl and fetch_byte_assembler.
package inst_fetch_ctrl_pkg;

  localparam int BYTE_W     = 8;
  localparam int INST_BYTES = 4;
  localparam int PF_STRIDE  = 4;

  typedef logic [BYTE_W-1:0] byte_bus_t;
  typedef logic [31:0]       inst_addr_t;
  typedef logic [31:0]       inst_bus_t;

  localparam inst_bus_t ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'b00,
    FETCH_BUSY  = 2'b01,
    FETCH_WRITE = 2'b10,
    FETCH_PREF  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_fetch_byte_assembler.sv
// Collects four little-endian bytes into one instruction word.
// clear_i wins over shift_i; done_o flags the byte that completes the word.
module fetch_byte_assembler
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [1:0]        cnt_o,
  output logic [WORD_W-1:0] word_next_o,
  output logic              done_o
);

  logic [1:0]        cnt_q;
  logic [WORD_W-1:0] buf_q;

  // Buffer with the incoming byte already dropped into its lane.
  always_comb begin
    word_next_o = buf_q;
    word_next_o[{cnt_q, 3'b000} +: BYTE_W] = byte_i;
  end

  assign cnt_o  = cnt_q;
  assign done_o = shift_i & ~clear_i & (cnt_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      buf_q <= '0;
    end else if (en_i) begin
      if (clear_i) begin
        cnt_q <= 2'd0;
        buf_q <= '0;
      end else if (shift_i) begin
        cnt_q <= cnt_q + 2'd1;
        buf_q <= word_next_o;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: cache hits return in one cycle, misses read four bytes
// and fill the cache. Optional next-line prefetch is enabled by defining INST_PREFETCH_EN.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rdy_i,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              if_valid_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ic_read_pc_o,
  input  logic              ic_hit_i,
  input  logic [INST_W-1:0] ic_inst_i,
  output logic              ic_we_o,
  output logic [ADDR_W-1:0] ic_write_pc_o,
  output logic [INST_W-1:0] ic_write_inst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [BYTE_W-1:0] mem_data_i
);

  // Handshakes: IF holds if_req_i/if_pc_i until a one-cycle if_valid_o pulse and is
  // re-sampled only the cycle after it; mem_req_o holds mem_addr_o until a mem_valid_i
  // byte is taken, and a byte counts only on a cycle with rdy_i high and flush_i low.

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [ADDR_W-1:0] ic_write_pc_q;
  logic [INST_W-1:0] if_inst_q;
  logic [INST_W-1:0] ic_write_inst_q;
  logic              mem_req_q;
  logic              if_valid_q;
  logic              ic_we_q;

  logic [1:0]        asm_cnt;
  logic [INST_W-1:0] asm_word_next;
  logic              asm_done;

  logic accept;
  logic start_miss;
  logic in_fetch;
  logic in_pref;
  logic abort_pref;
  logic pf_start;
  logic asm_shift;
  logic asm_clear;

  assign accept     = (state_q == FETCH_IDLE) & if_req_i & ~flush_i & ~if_valid_q;
  assign start_miss = accept & ~ic_hit_i;
  assign in_fetch   = (state_q == FETCH_BUSY);

`ifdef INST_PREFETCH_EN
  logic pf_pend_q;
  assign in_pref    = (state_q == FETCH_PREF);
  assign abort_pref = in_pref & (flush_i | if_req_i);
  assign pf_start   = (state_q == FETCH_IDLE) & pf_pend_q & ~if_req_i & ~flush_i;
`else
  assign in_pref    = 1'b0;
  assign abort_pref = 1'b0;
  assign pf_start   = 1'b0;
`endif

  assign asm_shift = mem_valid_i & ((in_fetch & ~flush_i) | (in_pref & ~abort_pref));
  assign asm_clear = start_miss | pf_start | flush_i | abort_pref;

  fetch_byte_assembler #(
    .WORD_W (INST_W)
  ) u_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (rdy_i),
    .clear_i     (asm_clear),
    .shift_i     (asm_shift),
    .byte_i      (mem_data_i),
    .cnt_o       (asm_cnt),
    .word_next_o (asm_word_next),
    .done_o      (asm_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= FETCH_IDLE;
      base_q          <= '0;
      if_pc_q         <= '0;
      if_inst_q       <= '0;
      ic_write_pc_q   <= '0;
      ic_write_inst_q <= '0;
      mem_req_q       <= 1'b0;
      if_valid_q      <= 1'b0;
      ic_we_q         <= 1'b0;
`ifdef INST_PREFETCH_EN
      pf_pend_q       <= 1'b0;
`endif
    end else if (rdy_i) begin
      ic_we_q    <= 1'b0;
      if_valid_q <= 1'b0;
      case (state_q)
        FETCH_IDLE: begin
          if (start_miss) begin
            base_q    <= if_pc_i;
            mem_req_q <= 1'b1;
            state_q   <= FETCH_BUSY;
          end else if (accept) begin
            if_valid_q <= 1'b1;
            if_inst_q  <= ic_inst_i;
            if_pc_q    <= if_pc_i;
          end
`ifdef INST_PREFETCH_EN
          else if (pf_start) begin
            base_q    <= base_q + ADDR_W'(PF_STRIDE);
            mem_req_q <= 1'b1;
            state_q   <= FETCH_PREF;
          end
          // Prefetch is only considered in the first idle cycle after a demand fill.
          pf_pend_q <= 1'b0;
`endif
        end
        FETCH_BUSY: begin
          if (flush_i) begin
            mem_req_q <= 1'b0;
            state_q   <= FETCH_IDLE;
          end else if (asm_done) begin
            mem_req_q       <= 1'b0;
            ic_we_q         <= 1'b1;
            ic_write_pc_q   <= base_q;
            ic_write_inst_q <= asm_word_next;
            if_valid_q      <= 1'b1;
            if_pc_q         <= base_q;
            if_inst_q       <= asm_word_next;
            state_q         <= FETCH_WRITE;
          end
        end
        FETCH_WRITE: begin
          state_q <= FETCH_IDLE;
`ifdef INST_PREFETCH_EN
          pf_pend_q <= if_valid_q & ~flush_i;
`endif
        end
`ifdef INST_PREFETCH_EN
        FETCH_PREF: begin
          if (abort_pref) begin
            mem_req_q <= 1'b0;
            state_q   <= FETCH_IDLE;
          end else if (asm_done) begin
            mem_req_q       <= 1'b0;
            ic_we_q         <= 1'b1;
            ic_write_pc_q   <= base_q;
            ic_write_inst_q <= asm_word_next;
            state_q         <= FETCH_WRITE;
          end
        end
`endif
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= FETCH_IDLE;
        end
      endcase
    end
  end

  // The cache write in WRITE survives a flush because the word is already complete.
  assign if_valid_o      = if_valid_q & rdy_i & ~flush_i;
  assign ic_we_o         = ic_we_q & rdy_i;
  assign if_inst_o       = if_inst_q;
  assign if_pc_o         = if_pc_q;
  assign busy_o          = (state_q != FETCH_IDLE);
  assign ic_read_pc_o    = if_pc_i;
  assign ic_write_pc_o   = ic_write_pc_q;
  assign ic_write_inst_o = ic_write_inst_q;
  assign mem_req_o       = mem_req_q;
  assign mem_addr_o      = base_q + ADDR_W'(asm_cnt);

endmodule
